// File: rtl/memwb_pkg.sv
// memwb_pkg: shared defaults and the beat payload carried from MEM to WB.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package memwb_pkg;

  localparam int MEMWB_XLEN      = 32;
  localparam int MEMWB_REGADDR_W = 5;

  typedef struct packed {
    logic [MEMWB_XLEN-1:0]      alu_out;
    logic [MEMWB_XLEN-1:0]      rdatamem;
    logic [MEMWB_REGADDR_W-1:0] rd;
    logic                       reg_write;
    logic                       mem_to_reg;
  } memwb_payload_t;

  // Writeback mux: load data when mem_to_reg, otherwise the ALU result.
  function automatic logic [MEMWB_XLEN-1:0] wb_select(input memwb_payload_t p);
    return p.mem_to_reg ? p.rdatamem : p.alu_out;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: single overflow entry that catches a beat accepted while the main entry is stalled.
// Latency: 1 cycle from load to valid; unload empties it on the next edge.
// Backpressure: none internally; the owner gates load with ~valid.
//
// Ports: clk, rst_n (async active-low), flush (sync kill), load/din (capture),
//        unload (hand entry to the main register), valid/dout (held entry).
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/memwb_pipe.sv
// memwb_pipe: MEM/WB pipeline register with valid/ready handshake, writeback select and stall counter.
// Latency: 1 cycle, 1 beat/cycle when out_ready_i is high.
// Backpressure: payload holds while stalled; in_ready_o is ~out_valid_o | out_ready_i,
//               or (with MEMWB_SKID_EN defined) registered ~skid_valid with a second entry.
//
// Ports: clk, rst_n (async active-low); in_valid_i/in_ready_o + alu_out_i, rdatamem_i, rd_i,
//        reg_write_i, mem_to_reg_i (MEM side); flush_i (sync kill); out_valid_o/out_ready_i +
//        alu_out_o, rdatamem_o, rd_o (WB side); wb_data_o, wb_we_o (regfile write);
//        stall_cnt_o (saturating count of stalled cycles).
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int XLEN      = MEMWB_XLEN,
  parameter int REGADDR_W = MEMWB_REGADDR_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [XLEN-1:0]      alu_out_i,
  input  logic [XLEN-1:0]      rdatamem_i,
  input  logic [REGADDR_W-1:0] rd_i,
  input  logic                 reg_write_i,
  input  logic                 mem_to_reg_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      alu_out_o,
  output logic [XLEN-1:0]      rdatamem_o,
  output logic [REGADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 wb_we_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  // The payload struct is sized by the package; the port widths must agree with it.
  if (XLEN != MEMWB_XLEN || REGADDR_W != MEMWB_REGADDR_W) begin : g_width_guard
    $error("memwb_pipe: XLEN/REGADDR_W must match memwb_pkg defaults");
  end

  memwb_payload_t in_beat;
  memwb_payload_t main_q;
  memwb_payload_t main_din;
  logic           main_vld;
  logic           main_load;     // main entry may change on this edge
  logic           main_next_vld;
  logic           out_xfer;

  assign in_beat = '{alu_out:    alu_out_i,
                     rdatamem:   rdatamem_i,
                     rd:         rd_i,
                     reg_write:  reg_write_i,
                     mem_to_reg: mem_to_reg_i};

  assign out_xfer = main_vld & out_ready_i;

`ifdef MEMWB_SKID_EN
  logic           skid_vld;
  memwb_payload_t skid_q;
  logic           in_xfer;

  assign in_ready_o = ~skid_vld;
  assign in_xfer    = in_valid_i & in_ready_o;

  // Main entry frees up when empty or draining; the skid beat is older than any
  // new input, so it goes first (and ready is low while it is occupied).
  assign main_load     = ~main_vld | out_ready_i;
  assign main_din      = skid_vld ? skid_q : in_beat;
  assign main_next_vld = skid_vld | in_xfer;

  pipe_skid_buf #(
    .W($bits(memwb_payload_t))
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush_i),
    .load   (in_xfer & main_vld & ~out_ready_i),
    .unload (skid_vld & out_xfer),
    .din    (in_beat),
    .valid  (skid_vld),
    .dout   (skid_q)
  );
`else
  assign in_ready_o    = ~main_vld | out_ready_i;
  assign main_load     = in_ready_o;
  assign main_din      = in_beat;
  assign main_next_vld = in_valid_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush_i) begin
      main_vld <= 1'b0;
    end else if (main_load) begin
      main_vld <= main_next_vld;
      if (main_next_vld) begin
        main_q <= main_din;
      end
    end
  end

  // Counts stalled cycles; sticks at all-ones and survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (main_vld && !out_ready_i && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign out_valid_o = main_vld;
  assign alu_out_o   = main_q.alu_out;
  assign rdatamem_o  = main_q.rdatamem;
  assign rd_o        = main_q.rd;
  assign wb_data_o   = wb_select(main_q);
  assign wb_we_o     = out_xfer & main_q.reg_write & (main_q.rd != '0);

endmodule
